// File: rtl/mc6801_timer_if.sv
// rtl/mc6801_timer_if.sv - CPU-side bus bundle for the 6801 timer responder
interface mc6801_timer_if;
  logic [15:0] address;
  logic        vma;
  logic        rw;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        sel;

  modport master (output address, vma, rw, data_in, input data_out, sel);
  modport slave  (input address, vma, rw, data_in, output data_out, sel);
endinterface

// File: rtl/mc6801_timer.sv
// rtl/mc6801_timer.sv - 6801 programmable timer: free-running counter, output compare, input capture
module mc6801_timer #(
  parameter logic [15:0] BASE = 16'h0008
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  mc6801_timer_if.slave  bus,
  input  logic           tin,
  output logic           tout,
  output logic           irq
);

  // ctl bits: [4] EICI, [3] EOCI, [2] ETOI, [1] IEDG, [0] OLVL
  // arm bits: [2] ICF, [1] OCF, [0] TOF
  logic [15:0] cnt_q, cnt_d, ocr_q, ocr_d, icr_q, icr_d;
  logic [4:0]  ctl_q, ctl_d;
  logic        icf_q, icf_d, ocf_q, ocf_d, tof_q, tof_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [2:0]  arm_q, arm_d;
  logic        pend_q, pend_d, cmp_en_q, cmp_en_d, tout_q, tout_d;
  logic [1:0]  sync_q;
  logic        last_q, last_d;

  logic [15:0] off;
  logic        acc, rd, wr;
  logic        rd_tcsr, rd_cnth, rd_icrh, rd_icrl;
  logic        wr_tcsr, wr_cnth, wr_ocrh, wr_ocrl;
  logic        tof_set, ocf_set, cap_edge, icf_set;
  logic        icf_clr, ocf_clr, tof_clr;

  assign off     = bus.address - BASE;
  assign bus.sel = bus.vma && (bus.address >= BASE) && (off <= 16'd6);
  assign acc     = ce & bus.sel;
  assign rd      = acc & bus.rw;
  assign wr      = acc & ~bus.rw;

  assign rd_tcsr = rd && off[2:0] == 3'd0;
  assign rd_cnth = rd && off[2:0] == 3'd1;
  assign rd_icrh = rd && off[2:0] == 3'd5;
  assign rd_icrl = rd && off[2:0] == 3'd6;
  assign wr_tcsr = wr && off[2:0] == 3'd0;
  assign wr_cnth = wr && off[2:0] == 3'd1;
  assign wr_ocrh = wr && off[2:0] == 3'd3;
  assign wr_ocrl = wr && off[2:0] == 3'd4;

  // Flag events; compare and capture both look at the pre-increment counter
  assign tof_set  = ce & ~wr_cnth & (cnt_q == 16'hFFFF);
  assign ocf_set  = ce & cmp_en_q & (cnt_q == ocr_q);
  assign cap_edge = ce & (ctl_q[1] ? (sync_q[1] & ~last_q) : (~sync_q[1] & last_q));
  assign icf_set  = cap_edge & ~pend_q;
  assign icf_clr  = rd_icrh & arm_q[2];
  assign ocf_clr  = (wr_ocrh | wr_ocrl) & arm_q[1];
  assign tof_clr  = rd_cnth & arm_q[0];

  assign tout = tout_q;
  assign irq  = (icf_q & ctl_q[4]) | (ocf_q & ctl_q[3]) | (tof_q & ctl_q[2]);

  // Zero-latency read mux over pre-edge register state
  always_comb begin
    bus.data_out = 8'h00;
    if (bus.sel && bus.rw) begin
      case (off[2:0])
        3'd0:    bus.data_out = {icf_q, ocf_q, tof_q, ctl_q};
        3'd1:    bus.data_out = cnt_q[15:8];
        3'd2:    bus.data_out = rbuf_q;
        3'd3:    bus.data_out = ocr_q[15:8];
        3'd4:    bus.data_out = ocr_q[7:0];
        3'd5:    bus.data_out = icr_q[15:8];
        3'd6:    bus.data_out = icr_q[7:0];
        default: bus.data_out = 8'h00;
      endcase
    end
  end

  // Next-state: counter, registers, flags with set-over-clear, arm bits and capture lock
  always_comb begin
    cnt_d    = cnt_q;
    ocr_d    = ocr_q;
    icr_d    = icr_q;
    ctl_d    = ctl_q;
    rbuf_d   = rbuf_q;
    pend_d   = pend_q;
    cmp_en_d = cmp_en_q;
    tout_d   = tout_q;
    last_d   = last_q;
    if (ce) begin
      last_d = sync_q[1];
      cnt_d  = wr_cnth ? 16'hFFF8 : cnt_q + 16'd1;
    end
    if (wr_tcsr) ctl_d = bus.data_in[4:0];
    if (wr_ocrh) begin
      ocr_d    = {bus.data_in, ocr_q[7:0]};
      cmp_en_d = 1'b0;
    end
    if (wr_ocrl) begin
      ocr_d    = {ocr_q[15:8], bus.data_in};
      cmp_en_d = 1'b1;
    end
    if (rd_cnth) rbuf_d = cnt_q[7:0];
    if (rd_icrh) pend_d = 1'b1;
    if (rd_icrl) pend_d = 1'b0;
    if (icf_set) icr_d = cnt_q;
    if (ocf_set) tout_d = ctl_q[0];

    icf_d = icf_set | (icf_q & ~icf_clr);
    ocf_d = ocf_set | (ocf_q & ~ocf_clr);
    tof_d = tof_set | (tof_q & ~tof_clr);
    arm_d = rd_tcsr ? (arm_q | {icf_q, ocf_q, tof_q})
                    : (arm_q & ~{icf_clr, ocf_clr, tof_clr});
  end

  // State registers; the tin synchronizer runs every clk, everything else moves only on ce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 16'h0000;
      ocr_q    <= 16'hFFFF;
      icr_q    <= 16'h0000;
      ctl_q    <= 5'd0;
      icf_q    <= 1'b0;
      ocf_q    <= 1'b0;
      tof_q    <= 1'b0;
      rbuf_q   <= 8'h00;
      arm_q    <= 3'd0;
      pend_q   <= 1'b0;
      cmp_en_q <= 1'b1;
      tout_q   <= 1'b0;
      sync_q   <= 2'd0;
      last_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ocr_q    <= ocr_d;
      icr_q    <= icr_d;
      ctl_q    <= ctl_d;
      icf_q    <= icf_d;
      ocf_q    <= ocf_d;
      tof_q    <= tof_d;
      rbuf_q   <= rbuf_d;
      arm_q    <= arm_d;
      pend_q   <= pend_d;
      cmp_en_q <= cmp_en_d;
      tout_q   <= tout_d;
      sync_q   <= {sync_q[0], tin};
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_mc6801_timer.sv
// tb/tb_mc6801_timer.sv - directed self-checking bench for mc6801_timer
module tb_mc6801_timer;

  localparam logic [15:0] TCSR = 16'h0008;
  localparam logic [15:0] CNTH = 16'h0009;
  localparam logic [15:0] CNTL = 16'h000A;
  localparam logic [15:0] OCRH = 16'h000B;
  localparam logic [15:0] OCRL = 16'h000C;
  localparam logic [15:0] ICRH = 16'h000D;
  localparam logic [15:0] ICRL = 16'h000E;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic tin = 1'b0;
  logic tout, irq;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] q;

  mc6801_timer_if bus();

  mc6801_timer #(.BASE(16'h0008)) dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .bus  (bus),
    .tin  (tin),
    .tout (tout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One E cycle: drive bus with ce high for one clk, sample read data before the edge
  task automatic cyc(input logic [15:0] a, input logic v, input logic r,
                     input logic [7:0] d, output logic [7:0] rq);
    bus.address = a;
    bus.vma     = v;
    bus.rw      = r;
    bus.data_in = d;
    ce          = 1'b1;
    #2 rq = bus.data_out;
    @(posedge clk);
    #1;
    ce      = 1'b0;
    bus.vma = 1'b0;
    bus.rw  = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] rq);
    cyc(a, 1'b1, 1'b1, 8'h00, rq);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] x;
    cyc(a, 1'b1, 1'b0, d, x);
  endtask

  task automatic tick(input int n);
    logic [7:0] x;
    for (int i = 0; i < n; i++) cyc(16'h0000, 1'b0, 1'b1, 8'h00, x);
  endtask

  initial begin
    bus.address = 16'h0000;
    bus.vma     = 1'b0;
    bus.rw      = 1'b1;
    bus.data_in = 8'h00;
    @(posedge clk);
    #1;
    check("rst_tout", tout, 0);
    check("rst_irq", irq, 0);
    check("rst_dout_idle", bus.data_out, 0);
    bus.vma = 1'b1;
    bus.address = 16'h000F; #1 check("sel_above", bus.sel, 0);
    bus.address = 16'h0007; #1 check("sel_below", bus.sel, 0);
    bus.address = ICRL;     #1 check("sel_top", bus.sel, 1);
    bus.vma = 1'b0;
    rst = 1'b0;

    // coherent counter read
    tick(3);
    rd(CNTH, q); check("cnth_3", q, 8'h00);
    tick(2);
    rd(CNTL, q); check("cntl_buf", q, 8'h03);
    rd(OCRH, q); check("rst_ocrh", q, 8'hFF);
    rd(OCRL, q); check("rst_ocrl", q, 8'hFF);
    rd(TCSR, q); check("rst_tcsr", q, 8'h00);
    rd(ICRH, q); check("rst_icrh", q, 8'h00);
    rd(ICRL, q); check("rst_icrl", q, 8'h00);

    // counter load, wrap, TOF/irq, clear sequence
    wr(TCSR, 8'h04);
    wr(CNTH, 8'h12);
    rd(CNTH, q); check("load_hi", q, 8'hFF);
    rd(CNTL, q); check("load_lo", q, 8'hF8);
    check("irq_pre_wrap", irq, 0);
    tick(6);
    check("irq_tof", irq, 1);
    rd(TCSR, q); check("tcsr_wrap", q, 8'h64);
    rd(CNTH, q); check("cnth_after_wrap", q, 8'h00);
    check("irq_tof_clr", irq, 0);
    rd(TCSR, q); check("tcsr_tof_clr", q, 8'h44);

    // compare disabled between OCRH and OCRL writes
    wr(TCSR, 8'h01);
    wr(OCRH, 8'hFF);
    wr(CNTH, 8'h00);
    tick(8);
    rd(TCSR, q); check("ocf_disabled", q, 8'h21);
    check("tout_disabled", tout, 0);

    // compare match at $0010
    wr(OCRH, 8'h00);
    wr(OCRL, 8'h10);
    tick(13);
    check("tout_before_match", tout, 0);
    tick(1);
    check("tout_match", tout, 1);

    // OCF clearing rules
    wr(OCRL, 8'h10);
    rd(TCSR, q); check("ocf_no_arm", q, 8'h61);
    wr(OCRL, 8'h10);
    rd(TCSR, q); check("ocf_cleared", q, 8'h21);
    wr(OCRH, 8'h00);
    wr(OCRL, 8'h1A);
    tick(4);
    wr(OCRL, 8'h20);
    rd(TCSR, q); check("ocf_rematch", q, 8'h61);
    tick(3);
    wr(OCRH, 8'h00);
    wr(OCRL, 8'h20);
    rd(TCSR, q); check("ocf_set_wins", q, 8'h61);

    // input capture, rising edge, blocked while ICR latch pending
    wr(TCSR, 8'h02);
    tin = 1'b1;
    tick(3);
    rd(TCSR, q); check("icf_set", q, 8'hE2);
    check("irq_no_en", irq, 0);
    rd(ICRH, q); check("icrh", q, 8'h00);
    tin = 1'b0;
    tick(3);
    tin = 1'b1;
    tick(3);
    rd(ICRL, q); check("icrl_blocked", q, 8'h26);
    rd(TCSR, q); check("icf_blocked", q, 8'h62);
    wr(TCSR, 8'h08);
    check("irq_ocf", irq, 1);
    check("tout_held", tout, 1);

    // asynchronous reset mid-operation
    bus.address = TCSR;
    bus.vma = 1'b1;
    bus.rw = 1'b1;
    #1 check("tcsr_pre_rst", bus.data_out, 8'h68);
    #2 rst = 1'b1;
    #1;
    check("arst_dout", bus.data_out, 8'h00);
    check("arst_irq", irq, 0);
    check("arst_tout", tout, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.vma = 1'b0;
    tick(2);
    rd(CNTH, q); check("post_rst_cnth", q, 8'h00);
    rd(CNTL, q); check("post_rst_cntl", q, 8'h02);
    rd(OCRH, q); check("post_rst_ocrh", q, 8'hFF);
    rd(ICRL, q); check("post_rst_icrl", q, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc6801_timer.md
# mc6801_timer

Bus-responder model of the 6801 on-chip programmable timer: a 16-bit free-running counter with output compare, input capture and overflow, mapped at $0008–$000E. It decodes the CPU-side address/vma/rw bus driven by the core's address multiplexer, returns read data, and raises a level interrupt request back to the core's interrupt logic.

## Interface
Parameters:
- BASE, 16'h0008, address of TCSR; registers occupy BASE..BASE+6.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ce  in  1  bus-cycle enable; one pulse per E cycle; all state updates only when ce=1
- address  in  16  CPU address
- vma  in  1  valid memory address
- rw  in  1  1=read, 0=write
- data_in  in  8  CPU write data
- data_out  out  8  read data; valid combinationally while selected and rw=1, else 8'h00
- sel  out  1  address in BASE..BASE+6 and vma=1 (combinational)
- tin  in  1  asynchronous input-capture pin
- tout  out  1  output-compare pin
- irq  out  1  (ICF&EICI)|(OCF&EOCI)|(TOF&ETOI)

## Operation
- Register map (offset): 0 TCSR {ICF,OCF,TOF,EICI,EOCI,ETOI,IEDG,OLVL}, bits 7:5 read-only; 1 CNTH; 2 CNTL; 3 OCRH; 4 OCRL; 5 ICRH; 6 ICRL. ICRH/ICRL read-only; writes ignored.
- Access event = ce & sel; side effects happen at the clk edge of that event.
- Counter: increments by 1 on every ce, wraps $FFFF→$0000 and sets TOF on wrap.
- Write to CNTH (offset 1): counter loads $FFF8 (write data ignored); the load has priority over increment that cycle. Writes to CNTL are ignored.
- Read of CNTH returns counter[15:8] and latches counter[7:0] into a read buffer; read of CNTL returns the buffer, giving a coherent 16-bit read. If CNTL is read without a preceding CNTH read, it returns the buffer contents (reset $00).
- Output compare: on each ce with compare enabled, if counter == OCR then OCF←1 and tout←OLVL. A write to OCRH disables compare until the next OCRL write; the OCRL write re-enables it.
- Input capture: tin passes through a 2-flop synchronizer; the edge selected by IEDG (1=rising, 0=falling), evaluated on ce, copies counter into ICR and sets ICF. A capture is blocked while the ICR latch is pending (see below).
- ICR read coherence: reading ICRH sets a pending flag that blocks capture until ICRL is read.
- Flag clearing: a TCSR read arms a per-flag clear bit for each flag that reads as 1. ICF is cleared by a subsequent ICRH read; OCF by a subsequent OCRH or OCRL write; TOF by a subsequent CNTH read. Only an armed flag clears, and its arm bit is dropped when it clears.
- Simultaneous set and clear of a flag in the same ce: set wins, and the arm bit is dropped.
- irq is combinational from the flags and enables.

## Timing
- Reset values: counter $0000, OCR $FFFF, ICR $0000, TCSR $00, read buffer $00, arm bits 0, ICR-pending 0, compare enabled, tout 0, irq 0.
- Reads have zero latency: data_out reflects register state before the edge of the access event.
- Writes take effect at the edge of the access event and are visible on the next ce.
- Compare is evaluated against the pre-increment counter value. OCF and tout update at the same edge.
- Input capture latency is 2 clk for synchronization plus up to the next ce. The captured value is the pre-increment counter at that ce.
- Flags set at the edge; irq follows in the same cycle after the edge.
- Reset asserted mid-operation forces all state to its reset values immediately; the first increment is on the first ce after rst deasserts.

## Test plan
- Reset, then 3 ce pulses → CNTH/CNTL read $00/$03 (read itself advances the counter; expect $0003 at CNTH and the buffered low byte $03 even after further ce).
- Write CNTH while counter = $1234 → next ce shows $FFF8; after 8 more ce, counter = $0000, TOF=1. With ETOI=1, irq=1. TCSR read, then CNTH read → TOF=0, irq=0.
- OCR ← $0010 (OCRH then OCRL), OLVL=1 → when counter = $0010 at ce, OCF=1 and tout=1. A ce between the OCRH and OCRL writes where counter matches the old value must not set OCF.
- IEDG=1, rising tin while counter ≈ $0100 → ICR = counter at capture ce, ICF=1. A second edge between ICRH and ICRL reads is ignored.
- OCRL write without a prior TCSR read → OCF stays 1. TCSR read, then OCRL write → OCF clears. TCSR read, then a compare match coinciding with the OCRH write → OCF stays 1.
- Assert rst with counter = $ABCD and all flags set → all registers return to reset values, and tout, irq and data_out are 0 asynchronously.
